// File: rtl/x_demux_ddr_mpc.sv
// -----------------------------------------------------------------------------
// x_demux_ddr_mpc
//   MPC-side DDR receiver. Captures two WIDTH-bit slices per clock cycle (one
//   on each edge), realigns them to the rising edge and presents them as a
//   1st-in-time / 2nd-in-time word pair. It also flags the all-ones idle
//   preset and runs a pattern-lock state machine for link qualification.
//
// Ports
//   clock      in   clock; DDR data toggles on both edges
//   reset_n    in   asynchronous active-low reset
//   clock_en   in   enable for output stage, FSM and error logic
//   din        in   DDR data from pins (WIDTH)
//   sync_en    in   1 = qualify received pairs against PAT1ST/PAT2ND
//   err_clr    in   synchronous clear of err_cnt / sync_lost (ignores clock_en)
//   dout1st    out  demuxed 1st-in-time word (WIDTH)
//   dout2nd    out  demuxed 2nd-in-time word (WIDTH)
//   idle       out  current pair is all ones in both slices
//   sync_lock  out  pattern lock achieved
//   sync_lost  out  sticky: lock was lost since last clear
//   err_cnt    out  saturating count of mismatches while locked (16)
// -----------------------------------------------------------------------------
module x_demux_ddr_mpc #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] PAT1ST     = 8'hA5,
   parameter logic [WIDTH-1:0] PAT2ND     = 8'h5A,
   parameter int               LOCK_COUNT = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clock_en,
   input  logic [WIDTH-1:0] din,
   input  logic             sync_en,
   input  logic             err_clr,
   output logic [WIDTH-1:0] dout1st,
   output logic [WIDTH-1:0] dout2nd,
   output logic             idle,
   output logic             sync_lock,
   output logic             sync_lost,
   output logic [15:0]      err_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // Counter value at which one more match declares lock.
   localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);

   logic [WIDTH-1:0] din_fall_q;
   logic [WIDTH-1:0] din_rise_q;
   logic [WIDTH-1:0] fall_hold_q;
   logic [WIDTH-1:0] dout1st_q, dout2nd_q;
   logic             idle_q;
   state_t           state_q;
   logic [7:0]       cnt_q;
   logic             lock_q;
   logic [15:0]      err_cnt_q, err_cnt_d;
   logic             lost_q, lost_d;
   logic             match;
   logic             loss;

   // ---------------------------------------------------------------- capture
   // 1st slice of cycle k lands on the falling edge inside cycle k.
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) din_fall_q <= '1;
      else          din_fall_q <= din;
   end

   // 2nd slice is taken at the rising edge closing cycle k; the 1st slice is
   // retimed on the same edge so the pair is rising-edge aligned. These run
   // regardless of clock_en.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         din_rise_q  <= '1;
         fall_hold_q <= '1;
      end else begin
         din_rise_q  <= din;
         fall_hold_q <= din_fall_q;
      end
   end

   // ----------------------------------------------------------- output stage
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dout1st_q <= '1;
         dout2nd_q <= '1;
         idle_q    <= 1'b1;
      end else if (clock_en) begin
         dout1st_q <= fall_hold_q;
         dout2nd_q <= din_rise_q;
         idle_q    <= (&fall_hold_q) & (&din_rise_q);
      end
   end

   // ------------------------------------------------------------- lock FSM
   // Compares the registered pair, i.e. what is currently on dout.
   assign match = (dout1st_q == PAT1ST) && (dout2nd_q == PAT2ND);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         lock_q  <= 1'b0;
      end else if (clock_en) begin
         if (!sync_en) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q <= ST_HUNT;
                  cnt_q   <= '0;
                  lock_q  <= 1'b0;
               end
               ST_HUNT: begin
                  if (!match) begin
                     cnt_q <= '0;
                  end else if (cnt_q == LOCK_LAST) begin
                     state_q <= ST_LOCKED;
                     cnt_q   <= '0;
                     lock_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               ST_LOCKED: begin
                  if (!match) begin
                     state_q <= ST_HUNT;
                     cnt_q   <= '0;
                     lock_q  <= 1'b0;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  lock_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------ error logic
   // A loss event is a mismatch seen while locked on an enabled edge.
   assign loss = clock_en && sync_en && (state_q == ST_LOCKED) && !match;

   always_comb begin
      err_cnt_d = err_cnt_q;
      lost_d    = lost_q;
      if (err_clr) begin
         // Clear wins over a coincident loss event.
         err_cnt_d = '0;
         lost_d    = 1'b0;
      end else if (loss) begin
         if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
         lost_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         err_cnt_q <= '0;
         lost_q    <= 1'b0;
      end else begin
         err_cnt_q <= err_cnt_d;
         lost_q    <= lost_d;
      end
   end

   assign dout1st   = dout1st_q;
   assign dout2nd   = dout2nd_q;
   assign idle      = idle_q;
   assign sync_lock = lock_q;
   assign sync_lost = lost_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_x_demux_ddr_mpc.sv
// -----------------------------------------------------------------------------
// tb_x_demux_ddr_mpc
//   Drives DDR pairs one cycle at a time and compares every output after each
//   rising edge against a cycle-level reference: a pair sent in cycle k is
//   shown once the following enabled edge moves it out of the capture stage,
//   and link qualification is tracked as a run length of consecutive matches.
// -----------------------------------------------------------------------------
module tb_x_demux_ddr_mpc;

   localparam int         W  = 8;
   localparam logic [7:0] P1 = 8'hA5;
   localparam logic [7:0] P2 = 8'h5A;
   localparam int         LC = 16;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         clock_en;
   logic [W-1:0] din;
   logic         sync_en;
   logic         err_clr;
   logic [W-1:0] dout1st, dout2nd;
   logic         idle, sync_lock, sync_lost;
   logic [15:0]  err_cnt;

   x_demux_ddr_mpc #(.WIDTH(W), .PAT1ST(P1), .PAT2ND(P2), .LOCK_COUNT(LC)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .clock_en  (clock_en),
      .din       (din),
      .sync_en   (sync_en),
      .err_clr   (err_clr),
      .dout1st   (dout1st),
      .dout2nd   (dout2nd),
      .idle      (idle),
      .sync_lock (sync_lock),
      .sync_lost (sync_lost),
      .err_cnt   (err_cnt)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   // Reference state
   logic [7:0] cap1, cap2;   // pair captured at the last edge, not yet shown
   logic [7:0] m1, m2;       // expected dout pair
   bit         m_idle, m_lock, m_lost, m_qual;
   int         m_run, m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      cap1 = 8'hFF; cap2 = 8'hFF;
      m1 = 8'hFF; m2 = 8'hFF; m_idle = 1'b1;
      m_lock = 1'b0; m_lost = 1'b0; m_qual = 1'b0;
      m_run = 0; m_err = 0;
   endtask

   task automatic check_all();
      chk("dout1st",   32'(dout1st),   32'(m1));
      chk("dout2nd",   32'(dout2nd),   32'(m2));
      chk("idle",      32'(idle),      32'(m_idle));
      chk("sync_lock", 32'(sync_lock), 32'(m_lock));
      chk("sync_lost", 32'(sync_lost), 32'(m_lost));
      chk("err_cnt",   32'(err_cnt),   32'(m_err));
   endtask

   // One 40 MHz cycle: slice a before the falling edge, slice b after it.
   // Controls set here are sampled at the rising edge closing the cycle.
   task automatic step(input logic [7:0] a, input logic [7:0] b,
                       input bit en, input bit sen, input bit clr);
      bit match;
      clock_en = en; sync_en = sen; err_clr = clr; din = a;
      @(negedge clock); #1 din = b;
      @(posedge clock);
      match = (m1 == P1) && (m2 == P2);
      if (clr) begin m_err = 0; m_lost = 1'b0; end
      if (en) begin
         if (!sen) begin
            m_qual = 1'b0; m_lock = 1'b0; m_run = 0;
         end else if (!m_qual) begin
            m_qual = 1'b1; m_run = 0;       // qualification starts next edge
         end else if (m_lock) begin
            if (!match) begin
               m_lock = 1'b0; m_run = 0;
               if (!clr) begin
                  m_lost = 1'b1;
                  if (m_err < 65535) m_err++;
               end
            end
         end else if (match) begin
            m_run++;
            if (m_run == LC) m_lock = 1'b1;
         end else begin
            m_run = 0;
         end
         m1 = cap1; m2 = cap2;
         m_idle = (m1 == 8'hFF) && (m2 == 8'hFF);
      end
      cap1 = a; cap2 = b;
      #1 check_all();
   endtask

   initial begin
      reset_n = 1'b0; din = 8'hFF; clock_en = 1'b0; sync_en = 1'b0; err_clr = 1'b0;
      model_reset();
      #12 check_all();                     // reset values
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Idle preset and first data pairs
      repeat (3) step(8'hFF, 8'hFF, 1, 0, 0);
      step(8'h12, 8'h34, 1, 0, 0);
      step(8'h56, 8'h78, 1, 0, 0);
      step(8'h00, 8'h00, 1, 0, 0);
      chk("pair_56", 32'({dout1st, dout2nd}), 32'h5678);
      step(8'hFF, 8'hFF, 1, 0, 0);
      step(8'hFF, 8'hFF, 1, 0, 0);

      // Random traffic with random enable, no sync
      repeat (30) step(8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0, 0, 0);

      // Continuous pattern: lock after 16 matches
      repeat (22) step(P1, P2, 1, 1, 0);
      chk("locked", 32'(sync_lock), 32'd1);

      // Back to idle, then a mismatch at match 10 restarts the run
      repeat (3) step(8'h00, 8'h00, 1, 0, 0);
      repeat (9) step(P1, P2, 1, 1, 0);
      step(8'h00, 8'h11, 1, 1, 0);
      repeat (20) step(P1, P2, 1, 1, 0);

      // Three isolated losses while locked, each followed by relock
      repeat (3) begin
         step(8'h00, 8'h11, 1, 1, 0);
         repeat (20) step(P1, P2, 1, 1, 0);
      end
      chk("err3", 32'(err_cnt), 32'd3);
      // 4th loss coincides with err_clr (loss evaluated two edges after send)
      step(8'h00, 8'h11, 1, 1, 0);
      step(P1, P2, 1, 1, 0);
      step(P1, P2, 1, 1, 1);
      step(P1, P2, 1, 1, 0);
      chk("clr_wins", 32'({sync_lost, err_cnt}), 32'd0);

      // Randomised qualification traffic
      repeat (400) begin
         logic [7:0] a, b;
         if ($urandom_range(0, 19) == 0) begin a = 8'($urandom); b = 8'($urandom); end
         else begin a = P1; b = P2; end
         step(a, b, $urandom_range(0, 9) != 0, $urandom_range(0, 59) != 0,
              $urandom_range(0, 39) == 0);
      end

      // Clock enable low: outputs and counters hold
      repeat (5) step(8'($urandom), 8'($urandom), 0, 1, 0);

      // Reset in the middle of hunting
      repeat (3) step(8'h00, 8'h00, 1, 0, 0);
      repeat (5) step(P1, P2, 1, 1, 0);
      din = 8'h3C;
      @(negedge clock); #1 din = 8'hC3;
      #1 reset_n = 1'b0;
      model_reset();
      #1 check_all();
      din = 8'hFF;
      @(posedge clock); #1 reset_n = 1'b1;
      repeat (4) step(8'hFF, 8'hFF, 1, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/x_demux_ddr_mpc.md
Name: x_demux_ddr_mpc

Overview:
- MPC-side receiver: captures an 80 MHz DDR data stream (two slices per 40 MHz cycle) and demultiplexes it into 1st-in-time and 2nd-in-time words aligned to the 40 MHz clock.
- Adds idle detection for the all-ones preset that the transmitter drives while held in set.
- Adds a pattern-lock state machine with a saturating error counter for link qualification at startup.

Parameters:
- WIDTH, 8, bits per DDR slice.
- PAT1ST, 8'hA5, expected 1st-in-time test word in sync mode (WIDTH bits).
- PAT2ND, 8'h5A, expected 2nd-in-time test word in sync mode (WIDTH bits).
- LOCK_COUNT, 16, consecutive matching cycles required to declare lock (range 1..255).

Ports:
- clock, in, 1, 40 MHz clock; DDR data toggles on both edges.
- reset_n, in, 1, asynchronous active-low reset.
- clock_en, in, 1, clock enable for output and sync logic.
- din, in, WIDTH, DDR input data from pins.
- sync_en, in, 1, 1 = compare the received pair against PAT1ST/PAT2ND.
- err_clr, in, 1, synchronous clear of err_cnt and sync_lost.
- dout1st, out, WIDTH, demuxed 1st-in-time word.
- dout2nd, out, WIDTH, demuxed 2nd-in-time word.
- idle, out, 1, current pair is all ones in both slices.
- sync_lock, out, 1, pattern lock achieved.
- sync_lost, out, 1, sticky flag: lock was lost since the last clear.
- err_cnt, out, 16, saturating count of mismatches while locked.

Behaviour:
- Reset (reset_n=0, asynchronous), output values:
  - dout1st and dout2nd = all ones, which matches the transmitter preset.
  - idle=1, sync_lock=0, sync_lost=0, err_cnt=0.
  - FSM goes to IDLE; match counter=0; capture flops = all ones.
- Capture:
  - din_fall is sampled on the falling edge of clock and holds the 1st slice of cycle k.
  - din_rise is sampled on the rising edge of clock at the end of cycle k and holds the 2nd slice of cycle k.
  - On that same rising edge, din_fall is retimed into a rising-edge holding flop so both slices are rising-edge aligned.
- Output stage:
  - On the next rising edge with clock_en=1: dout1st <= held 1st slice, dout2nd <= din_rise, idle <= (both == all ones).
  - Fixed latency: a pair transmitted in cycle k appears on dout after rising edge k+2.
  - clock_en=0: dout, idle, FSM, match counter and err_cnt all hold. Capture flops keep running.
- The FSM evaluates only on clock_en=1 and uses the registered dout pair. match = (dout1st==PAT1ST && dout2nd==PAT2ND).
  - IDLE: sync_lock=0, match counter=0. If sync_en=1, go to HUNT.
  - HUNT:
    - On match, the counter increments. When the counter reaches LOCK_COUNT-1 and another match arrives, go to LOCKED with sync_lock=1.
    - On mismatch, counter=0 and the state stays HUNT.
    - Mismatches in HUNT never touch err_cnt.
  - LOCKED:
    - On match, stay.
    - On mismatch: err_cnt+1 (saturates at 16'hFFFF, no wrap), sync_lost=1, sync_lock=0, counter=0, go to HUNT.
  - Any state with sync_en=0: go to IDLE on the next enabled edge. sync_lock clears; err_cnt and sync_lost are retained.
- err_clr=1 (independent of clock_en):
  - err_cnt=0 and sync_lost=0 on the next rising edge.
  - If it coincides with an increment or loss event, clear wins.
  - The FSM state is unaffected.
- LOCK_COUNT=1: the first match in HUNT locks.
- Reset asserted mid-operation: all state returns to reset values immediately. Outputs show all ones until two enabled edges after release.

Test Plan:
- Reset, release, drive din all ones on both edges -> dout1st=dout2nd=8'hFF, idle=1, sync_lock=0, err_cnt=0.
- Drive pairs (8'h12,8'h34), (8'h56,8'h78) in cycles k and k+1 -> dout1st/dout2nd = 12/34 after edge k+2 and 56/78 after edge k+3; idle=0.
- sync_en=1, drive PAT1ST/PAT2ND continuously -> sync_lock rises on the 16th consecutive enabled match.
- Inject one mismatch at match 10, then 16 good pairs -> no lock until 16 matches after the mismatch; err_cnt stays 0.
- While locked, inject 3 isolated mismatches separated by 16+ good cycles -> err_cnt=3, sync_lost=1, relock after each. Assert err_clr on the same cycle as a 4th mismatch -> err_cnt=0, sync_lost=0.
- clock_en=0 for 5 cycles with changing din -> dout and err_cnt frozen. Then reset_n low mid-HUNT -> outputs all ones, sync_lock=0 asynchronously.
